// File: rtl/rpi_frame_pkg.sv
// rtl/rpi_frame_pkg.sv - shared constants and FSM state type for the Pi frame receiver
package rpi_frame_pkg;

   localparam int         FRAME_BYTES       = 8;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      DATA = 2'd1,
      CSUM = 2'd2
   } rx_state_e;

endpackage

// File: rtl/rpi_strobe_sync.sv
// rtl/rpi_strobe_sync.sv - two-flop synchroniser for Pi strobe/data with strobe falling-edge detect
module rpi_strobe_sync (
   input  logic       clk_100mhz,
   input  logic       rst_n,
   input  logic       write_strobe_i,
   input  logic [7:0] rpi_io_i,
   output logic       byte_stb,
   output logic [7:0] byte_data
);

   // [0],[1] are the sync stages, [2] is the delayed copy; all reset high so no edge after reset
   logic [2:0] strb_q;
   logic [7:0] data_s1_q;
   logic [7:0] data_s2_q;

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         strb_q    <= 3'b111;
         data_s1_q <= 8'h00;
         data_s2_q <= 8'h00;
      end else begin
         strb_q    <= {strb_q[1:0], write_strobe_i};
         data_s1_q <= rpi_io_i;
         data_s2_q <= data_s1_q;
      end
   end

   assign byte_stb  = !strb_q[1] && strb_q[2];
   assign byte_data = data_s2_q;

endmodule

// File: rtl/rpi_frame_rx.sv
// rtl/rpi_frame_rx.sv - Pi parallel-bus frame receiver: sync, hunt/assemble, valid/ready output, sticky errors
// Define RPI_FRAME_RX_CHECKSUM_EN to append and verify an XOR checksum byte after the 8 data bytes.
module rpi_frame_rx
   import rpi_frame_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
   parameter int         IDLE_TIMEOUT = 100000
) (
   input  logic        clk_100mhz,
   input  logic        rst_n,
   input  logic [7:0]  RPI_IO,
   input  logic        write_strobe,
   output logic [63:0] frame_data,
   output logic        frame_valid,
   input  logic        frame_ready,
   input  logic        err_clear,
   output logic        err_checksum,
   output logic        err_timeout,
   output logic        err_overflow
);

   localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_TIMEOUT);

   logic        byte_stb;
   logic [7:0]  byte_data;

   rx_state_e                  state_q, state_d;
   logic [2:0]                 idx_q, idx_d;
   logic [FRAME_BYTES*8-1:0]   asm_q, asm_d;
   logic [IDLE_W-1:0]          idle_q, idle_d;
   logic [63:0]                fdata_q, fdata_d;
   logic                       fvalid_q, fvalid_d;
   logic                       err_to_q, err_to_d;
   logic                       err_ov_q, err_ov_d;
   logic                       done, load, to_set;
   logic [63:0]                done_data;
`ifdef RPI_FRAME_RX_CHECKSUM_EN
   logic [7:0]                 acc_q, acc_d;
   logic                       err_ck_q, err_ck_d;
   logic                       ck_set;
`endif

   rpi_strobe_sync u_sync (
      .clk_100mhz     (clk_100mhz),
      .rst_n          (rst_n),
      .write_strobe_i (write_strobe),
      .rpi_io_i       (RPI_IO),
      .byte_stb       (byte_stb),
      .byte_data      (byte_data)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      done      = 1'b0;
      done_data = asm_q;
      to_set    = 1'b0;
`ifdef RPI_FRAME_RX_CHECKSUM_EN
      acc_d     = acc_q;
      ck_set    = 1'b0;
`endif
      idle_d = byte_stb ? '0 : ((idle_q == IDLE_LIM) ? idle_q : idle_q + 1'b1);

      if (byte_stb) begin
         case (state_q)
            HUNT: begin
               if (byte_data == SYNC_BYTE) begin
                  state_d = DATA;
                  idx_d   = 3'd0;
`ifdef RPI_FRAME_RX_CHECKSUM_EN
                  acc_d   = 8'h00;
`endif
               end
            end
            DATA: begin
               asm_d[{idx_q, 3'b000} +: 8] = byte_data;
               idx_d = idx_q + 3'd1;
`ifdef RPI_FRAME_RX_CHECKSUM_EN
               acc_d = acc_q ^ byte_data;
               if (idx_q == 3'd7) state_d = CSUM;
`else
               if (idx_q == 3'd7) begin
                  state_d   = HUNT;
                  done      = 1'b1;
                  done_data = asm_d;
               end
`endif
            end
`ifdef RPI_FRAME_RX_CHECKSUM_EN
            CSUM: begin
               state_d = HUNT;
               if (byte_data == acc_q) done   = 1'b1;
               else                    ck_set = 1'b1;
            end
`endif
            default: state_d = HUNT;
         endcase
      end else if (state_q != HUNT && idle_q == IDLE_LIM) begin
         state_d = HUNT;
         to_set  = 1'b1;
      end

      // A completing frame may load in the same cycle the held one drains
      load     = done && (!fvalid_q || frame_ready);
      fvalid_d = (fvalid_q && !frame_ready) || load;
      fdata_d  = load ? done_data : fdata_q;
      err_to_d = (err_to_q && !err_clear) || to_set;
      err_ov_d = (err_ov_q && !err_clear) || (done && !load);
`ifdef RPI_FRAME_RX_CHECKSUM_EN
      err_ck_d = (err_ck_q && !err_clear) || ck_set;
`endif
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HUNT;
         idx_q    <= 3'd0;
         asm_q    <= '0;
         idle_q   <= '0;
         fdata_q  <= 64'h0;
         fvalid_q <= 1'b0;
         err_to_q <= 1'b0;
         err_ov_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         asm_q    <= asm_d;
         idle_q   <= idle_d;
         fdata_q  <= fdata_d;
         fvalid_q <= fvalid_d;
         err_to_q <= err_to_d;
         err_ov_q <= err_ov_d;
      end
   end

`ifdef RPI_FRAME_RX_CHECKSUM_EN
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= 8'h00;
         err_ck_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         err_ck_q <= err_ck_d;
      end
   end
   assign err_checksum = err_ck_q;
`else
   assign err_checksum = 1'b0;
`endif

   assign frame_data   = fdata_q;
   assign frame_valid  = fvalid_q;
   assign err_timeout  = err_to_q;
   assign err_overflow = err_ov_q;

endmodule

// File: tb/tb_rpi_frame_rx.sv
// tb/tb_rpi_frame_rx.sv - self-checking bench for rpi_frame_rx: vector table, corner sequences, random frames vs model
module tb_rpi_frame_rx;

   localparam logic [7:0] SYNC    = 8'hA5;
   localparam int         IDLE_TO = 40;
`ifdef RPI_FRAME_RX_CHECKSUM_EN
   localparam bit CK   = 1'b1;
   localparam int FLEN = 9;
`else
   localparam bit CK   = 1'b0;
   localparam int FLEN = 8;
`endif

   typedef struct {
      string       name;
      logic [7:0]  j0;
      logic [7:0]  j1;
      int          nj;
      logic [63:0] data;
      logic [7:0]  ck_xor;
      int          exp_n;
      logic        exp_ck;
   } vec_t;

   logic        clk_100mhz   = 1'b0;
   logic        rst_n        = 1'b0;
   logic [7:0]  RPI_IO       = 8'h00;
   logic        write_strobe = 1'b1;
   logic        frame_ready  = 1'b0;
   logic        err_clear    = 1'b0;
   logic [63:0] frame_data;
   logic        frame_valid;
   logic        err_checksum;
   logic        err_timeout;
   logic        err_overflow;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] got[$];
   vec_t        tbl[5];

   bit          m_hunt;
   bit          m_ck;
   logic [7:0]  m_buf[$];
   logic [63:0] exp_q[$];
   logic [7:0]  seg[$];
   logic [63:0] rd;
   logic [7:0]  rx;
   int          r;

   always #5 clk_100mhz = ~clk_100mhz;

   rpi_frame_rx #(.SYNC_BYTE(SYNC), .IDLE_TIMEOUT(IDLE_TO)) dut (
      .clk_100mhz   (clk_100mhz),
      .rst_n        (rst_n),
      .RPI_IO       (RPI_IO),
      .write_strobe (write_strobe),
      .frame_data   (frame_data),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready),
      .err_clear    (err_clear),
      .err_checksum (err_checksum),
      .err_timeout  (err_timeout),
      .err_overflow (err_overflow)
   );

   // Handshakes are sampled mid-cycle, before the edge that completes them
   always @(negedge clk_100mhz)
      if (rst_n && frame_valid && frame_ready) got.push_back(frame_data);

   task automatic tick();
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] got_at(input int i);
      if (i < got.size()) return got[i];
      return 'x;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit raise);
      int pre = $urandom_range(3, 6);
      int low = $urandom_range(3, 5);
      RPI_IO = b;
      repeat (pre) tick();
      write_strobe = 1'b0;
      for (int i = 0; i < low; i++) begin
         tick();
         if (raise && i == 1) frame_ready = 1'b1;
      end
      write_strobe = 1'b1;
   endtask

   task automatic send_frame(input logic [63:0] d, input logic [7:0] ck_xor, input bit raise);
      logic [7:0] x = 8'h00;
      send_byte(SYNC, 1'b0);
      for (int i = 0; i < 8; i++) begin
         send_byte(d[i*8 +: 8], raise && !CK && i == 7);
         x ^= d[i*8 +: 8];
      end
      if (CK) send_byte(x ^ ck_xor, raise);
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      tick();
   endtask

   // Frame = sync marker then FLEN payload bytes; a bad trailing XOR drops the frame
   function automatic void model_feed(input logic [7:0] b);
      logic [63:0] f = 64'h0;
      logic [7:0]  x = 8'h00;
      if (m_hunt) begin
         if (b == SYNC) begin
            m_hunt = 1'b0;
            m_buf.delete();
         end
      end else begin
         m_buf.push_back(b);
         if (m_buf.size() == FLEN) begin
            for (int i = 0; i < 8; i++) begin
               f[i*8 +: 8] = m_buf[i];
               x ^= m_buf[i];
            end
            if (FLEN == 8 || m_buf[8] == x) exp_q.push_back(f);
            else m_ck = 1'b1;
            m_hunt = 1'b1;
         end
      end
   endfunction

   initial begin
      tbl[0] = '{"plain",   8'h00, 8'h00, 0, 64'h0807060504030201, 8'h00, 1, 1'b0};
      tbl[1] = '{"junk",    8'h33, 8'h44, 2, 64'h0807060504030201, 8'h00, 1, 1'b0};
      tbl[2] = '{"sync_in", 8'h00, 8'h00, 0, 64'hA5A500FFA51234A5, 8'h00, 1, 1'b0};
      tbl[3] = '{"bad_ck",  8'h00, 8'h00, 0, 64'h0807060504030201, 8'h08, CK ? 0 : 1, CK};
      tbl[4] = '{"zeros",   8'h5A, 8'h00, 1, 64'h0000000000000000, 8'h00, 1, 1'b0};

      repeat (3) tick();
      chk("rst_valid", {63'h0, frame_valid}, 64'h0);
      chk("rst_data", frame_data, 64'h0);
      chk("rst_ck", {63'h0, err_checksum}, 64'h0);
      chk("rst_to", {63'h0, err_timeout}, 64'h0);
      chk("rst_ov", {63'h0, err_overflow}, 64'h0);
      rst_n = 1'b1;
      tick();

      frame_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         got.delete();
         for (int j = 0; j < tbl[v].nj; j++) send_byte(j == 0 ? tbl[v].j0 : tbl[v].j1, 1'b0);
         send_frame(tbl[v].data, tbl[v].ck_xor, 1'b0);
         repeat (6) tick();
         chk({tbl[v].name, "_count"}, 64'(got.size()), 64'(tbl[v].exp_n));
         if (tbl[v].exp_n > 0) chk({tbl[v].name, "_data"}, got_at(0), tbl[v].data);
         chk({tbl[v].name, "_ck"}, {63'h0, err_checksum}, {63'h0, tbl[v].exp_ck});
         chk({tbl[v].name, "_to"}, {63'h0, err_timeout}, 64'h0);
         chk({tbl[v].name, "_ov"}, {63'h0, err_overflow}, 64'h0);
         pulse_clear();
         chk({tbl[v].name, "_ck_clr"}, {63'h0, err_checksum}, 64'h0);
      end

      // Partial frame abandoned after the idle limit; HUNT resumes cleanly
      got.delete();
      send_byte(SYNC, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      repeat (20) tick();
      chk("to_early", {63'h0, err_timeout}, 64'h0);
      repeat (25) tick();
      chk("to_set", {63'h0, err_timeout}, 64'h1);
      send_frame(64'h1122334455667788, 8'h00, 1'b0);
      repeat (6) tick();
      chk("to_next_count", 64'(got.size()), 64'd1);
      chk("to_next_data", got_at(0), 64'h1122334455667788);
      pulse_clear();
      chk("to_clr", {63'h0, err_timeout}, 64'h0);

      // Overflow: second frame dropped while the first is held
      frame_ready = 1'b0;
      got.delete();
      send_frame(64'hAAAA0000BBBB1111, 8'h00, 1'b0);
      send_frame(64'hCCCC2222DDDD3333, 8'h00, 1'b0);
      repeat (4) tick();
      chk("ov_valid", {63'h0, frame_valid}, 64'h1);
      chk("ov_held", frame_data, 64'hAAAA0000BBBB1111);
      chk("ov_flag", {63'h0, err_overflow}, 64'h1);
      frame_ready = 1'b1;
      repeat (4) tick();
      chk("ov_drain_count", 64'(got.size()), 64'd1);
      chk("ov_drain_valid", {63'h0, frame_valid}, 64'h0);
      frame_ready = 1'b0;
      pulse_clear();
      chk("ov_clr", {63'h0, err_overflow}, 64'h0);

      // Ready rises on the very edge the second frame completes
      got.delete();
      send_frame(64'h0102030405060708, 8'h00, 1'b0);
      send_frame(64'hF0E0D0C0B0A09080, 8'h00, 1'b1);
      repeat (6) tick();
      chk("same_cyc_count", 64'(got.size()), 64'd2);
      chk("same_cyc_d0", got_at(0), 64'h0102030405060708);
      chk("same_cyc_d1", got_at(1), 64'hF0E0D0C0B0A09080);
      chk("same_cyc_ov", {63'h0, err_overflow}, 64'h0);

      // Reset mid-frame with a held frame and a sticky error
      frame_ready = 1'b0;
      got.delete();
      send_frame(64'h1111111111111111, 8'h00, 1'b0);
      send_frame(64'h2222222222222222, 8'h00, 1'b0);
      send_byte(SYNC, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0);
      chk("pre_rst_ov", {63'h0, err_overflow}, 64'h1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {63'h0, frame_valid}, 64'h0);
      chk("mid_rst_data", frame_data, 64'h0);
      chk("mid_rst_ov", {63'h0, err_overflow}, 64'h0);
      chk("mid_rst_to", {63'h0, err_timeout}, 64'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      frame_ready = 1'b1;
      send_frame(64'h0F1E2D3C4B5A6978, 8'h00, 1'b0);
      repeat (6) tick();
      chk("post_rst_count", 64'(got.size()), 64'd1);
      chk("post_rst_data", got_at(0), 64'h0F1E2D3C4B5A6978);

      // Random mix of junk, good frames and corrupted checksums
      pulse_clear();
      got.delete();
      exp_q.delete();
      m_hunt = 1'b1;
      m_ck   = 1'b0;
      for (int s = 0; s < 25; s++) begin
         seg.delete();
         r = $urandom_range(0, 9);
         if (r < 2) begin
            for (int k = $urandom_range(1, 3); k > 0; k--) seg.push_back(8'($urandom));
         end else begin
            rd = {$urandom, $urandom};
            rx = 8'h00;
            seg.push_back(SYNC);
            for (int i = 0; i < 8; i++) begin
               seg.push_back(rd[i*8 +: 8]);
               rx ^= rd[i*8 +: 8];
            end
            if (CK) seg.push_back(rx ^ ((r == 9) ? 8'h5A : 8'h00));
         end
         foreach (seg[i]) begin
            model_feed(seg[i]);
            send_byte(seg[i], 1'b0);
         end
      end
      repeat (8) tick();
      chk("rand_count", 64'(got.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) chk($sformatf("rand_data%0d", i), got_at(i), exp_q[i]);
      chk("rand_ck", {63'h0, err_checksum}, {63'h0, m_ck});
      chk("rand_ov", {63'h0, err_overflow}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rpi_frame_rx.md
# rpi_frame_rx

Upstream receive stage for the Raspberry Pi parallel bus. Synchronises `RPI_IO` and `write_strobe` into the `clk_100mhz` domain, captures one byte per strobe falling edge, assembles framed 8-byte patterns, and hands each complete 64-bit pattern to the matrix output driver over a valid/ready handshake. Framing errors, timeouts and overruns are reported on sticky flags.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `IDLE_TIMEOUT`, default 100000: idle cycles between bytes before a partial frame is abandoned (1 ms at 100 MHz). Must be ≥ 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_100mhz`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `RPI_IO`  in  8: Pi data bus; asynchronous to `clk_100mhz`.
- `write_strobe`  in  1: Pi strobe; idle high; a byte is valid on its falling edge.
- `frame_data`  out  64: assembled pattern; first data byte in [7:0], eighth in [63:56].
- `frame_valid`  out  1: `frame_data` holds an unconsumed pattern.
- `frame_ready`  in  1: downstream accepts when `frame_valid && frame_ready`.
- `err_clear`  in  1: one-cycle pulse that clears all sticky errors.
- `err_checksum`  out  1: sticky; checksum mismatch.
- `err_timeout`  out  1: sticky; partial frame abandoned.
- `err_overflow`  out  1: sticky; completed frame dropped because the output was still full.

## Operation
- Synchroniser:
  - `write_strobe` and `RPI_IO` each pass through two flops; a third flop on strobe gives edge detection.
  - Strobe flops reset to 1, so no false edge occurs after reset.
  - Falling edge: synced strobe is 0 while the delayed copy is 1. The synced `RPI_IO` is the byte captured in that cycle (cycle E).
- FSM states: HUNT, DATA, CSUM.
  - HUNT: a byte equal to `SYNC_BYTE` goes to DATA, clears the byte index and the running XOR. Any other byte is ignored.
  - DATA: each byte is written to slot `idx` of the assembly register and XORed into the accumulator. `idx` counts 0..7. On the byte at `idx == 7` → CSUM (checksum build) or frame complete → HUNT (no-checksum build). `SYNC_BYTE` inside DATA is ordinary data.
  - CSUM: byte == accumulator → frame complete. Byte ≠ accumulator → set `err_checksum` and discard the frame. Both cases → HUNT.
- Frame completion:
  - Output register empty, or drained this cycle (`frame_valid && frame_ready`): load `frame_data`, `frame_valid` = 1.
  - Otherwise: drop the new frame, keep the held one, set `err_overflow`.
- Timeout:
  - Idle counter clears on every edge and increments otherwise, saturating.
  - In DATA or CSUM, reaching `IDLE_TIMEOUT` → HUNT and set `err_timeout`. Partial data is discarded. HUNT never times out.
- Sticky errors: `err_clear` clears all three. If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values: `frame_data` 0, `frame_valid` 0, all error flags 0; FSM in HUNT; `idx` 0; idle counter 0.
- Pin-to-edge latency: 3 `clk_100mhz` cycles (two sync flops plus the edge register).
- Completion: on a completing edge in cycle E, `frame_valid` is high in cycle E+1. Error flags also update in cycle E+1.
- `frame_valid` falls the cycle after the handshake, unless a new frame loads in that same cycle.
- Pi constraint: strobe low and high phases each ≥ 3 clocks (30 ns); data stable from 30 ns before to 30 ns after the falling edge. Shorter pulses may be missed; no metastability hazard propagates.
- Rate: at most one byte per 6 clocks; the FSM has no back-pressure to the Pi.
- Reset assertion mid-frame aborts everything immediately. The first edge after deassertion is treated as a HUNT byte.

## Configuration
- `RPI_FRAME_RX_CHECKSUM_EN` defined:
  - Frame is `SYNC_BYTE`, 8 data bytes, then the XOR of the 8 data bytes.
  - CSUM state present; `err_checksum` is functional.
- Undefined:
  - Frame is `SYNC_BYTE` plus 8 data bytes; completion happens on the 8th data byte.
  - CSUM state and accumulator are removed; `err_checksum` is tied to 0.

## Structure
- Package `rpi_frame_pkg`: `FRAME_BYTES` = 8, the state enum `{HUNT, DATA, CSUM}`, and the default `SYNC_BYTE` constant.
- Sub-module `rpi_strobe_sync`: 2-flop data/strobe synchroniser plus falling-edge detect. Outputs `byte_stb` (1-cycle pulse) and `byte_data[7:0]`.
- Top level holds the FSM, assembly register, output register and error logic.

## Test plan
- Send A5, 01..08, checksum 08 with `frame_ready` = 1 → one `frame_valid` pulse, `frame_data` = 64'h0807060504030201, no errors.
- Send 33, 44, then a valid frame → 33 and 44 are ignored; frame delivered as above.
- Valid frame with checksum byte 00 → no `frame_valid`, `err_checksum` = 1; pulse `err_clear` → 0.
- A5, 3 data bytes, then idle for `IDLE_TIMEOUT` + 1 clocks → `err_timeout` = 1 and FSM in HUNT; the next full frame is delivered correctly.
- Hold `frame_ready` = 0 and send two valid frames → the first is held in `frame_data`, `err_overflow` = 1. Raise ready on the cycle the second completes → the second loads and no overflow is flagged.
- Assert `rst_n` low after 4 data bytes → all outputs return to reset values; the following full frame is delivered correctly.
